// File: rtl/universal_shift_reg.sv
// ---------------------------------------------------------------------------
// universal_shift_reg
//   WIDTH-bit shift register with eight operations (hold, shift left/right,
//   rotate left/right, arithmetic shift right, parallel load, clear).
//   Operations run either as a single step in IDLE, or as a counted burst:
//   a start pulse latches a shift/rotate mode plus a step count, and the
//   block repeats that operation once per enabled cycle until the count is
//   exhausted, then pulses done.
//
// Ports
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset
//   en       : step enable in IDLE, burst stall (low = hold) in BURST
//   mode     : 000 HOLD 001 SHL 010 SHR 011 ROL 100 ROR 101 ASR 110 LOAD 111 CLR
//   din_l    : serial bit shifted into the LSB on SHL
//   din_r    : serial bit shifted into the MSB on SHR
//   pdata    : parallel load value
//   start    : burst request, looked at in IDLE only
//   count    : number of burst steps
//   q        : register contents
//   so_l     : q[WIDTH-1], combinational
//   so_r     : q[0], combinational
//   busy     : high while a burst is in progress
//   done     : one-cycle pulse after a burst completes
// ---------------------------------------------------------------------------
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             din_l,
    input  logic             din_r,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             so_l,
    output logic             so_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_ROL  = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ASR  = 3'b101;
    localparam logic [2:0] M_LOAD = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       mode_r, mode_nxt;
    logic [CNT_W-1:0] rem, rem_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             done_nxt;

    // One application of an operation to the current register value.
    function automatic logic [WIDTH-1:0] step(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] ld,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        r = v;
        case (m)
            M_SHL:  r = {v[WIDTH-2:0], sl};
            M_SHR:  r = {sr, v[WIDTH-1:1]};
            M_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            M_ROR:  r = {v[0], v[WIDTH-1:1]};
            M_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            M_LOAD: r = ld;
            M_CLR:  r = '0;
            default: r = v;
        endcase
        return r;
    endfunction

    // Only the shift/rotate modes make sense repeated; LOAD/CLR/HOLD bursts
    // are treated as plain single-step cycles.
    logic burst_mode;
    assign burst_mode = (mode == M_SHL) || (mode == M_SHR) || (mode == M_ROL) ||
                        (mode == M_ROR) || (mode == M_ASR);

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_r;
        rem_nxt   = rem;
        q_nxt     = q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start && burst_mode) begin
                    // Accept edge: latch the burst, q untouched this edge.
                    state_nxt = BURST;
                    mode_nxt  = mode;
                    rem_nxt   = count;
                end else if (en) begin
                    q_nxt = step(mode, q, pdata, din_l, din_r);
                end
            end
            BURST: begin
                if (en) begin
                    if (rem == '0) begin
                        // Terminal edge spends a cycle with no shift so done
                        // lands in a cycle where the block is already IDLE.
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        q_nxt   = step(mode_r, q, pdata, din_l, din_r);
                        rem_nxt = rem - 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            mode_r <= M_HOLD;
            rem    <= '0;
            q      <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            mode_r <= mode_nxt;
            rem    <= rem_nxt;
            q      <= q_nxt;
            done   <= done_nxt;
        end
    end

    assign busy = (state == BURST);
    assign so_l = q[WIDTH-1];
    assign so_r = q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_ROL  = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ASR  = 3'b101;
    localparam logic [2:0] M_LOAD = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [2:0] mode;
    logic       din_l;
    logic       din_r;
    logic [7:0] pdata;
    logic       start;
    logic [3:0] count;
    logic [7:0] q;
    logic       so_l;
    logic       so_r;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    // Scoreboard: expected post-edge state queued when a cycle is driven.
    logic [7:0] exp_q[$];
    logic       exp_b[$];
    logic       exp_d[$];
    string      exp_t[$];

    universal_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode),
        .din_l(din_l), .din_r(din_r), .pdata(pdata), .start(start),
        .count(count), .q(q), .so_l(so_l), .so_r(so_r),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_pop();
        logic [7:0] eq;
        logic       eb, ed;
        string      t;
        total++;
        assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL scoreboard empty: got 0 entries want >0");
        end
        if (exp_q.size() > 0) begin
            eq = exp_q.pop_front();
            eb = exp_b.pop_front();
            ed = exp_d.pop_front();
            t  = exp_t.pop_front();
            total++;
            assert (q === eq) else begin
                bad++; $error("FAIL %s q: got %h want %h", t, q, eq);
            end
            total++;
            assert (busy === eb) else begin
                bad++; $error("FAIL %s busy: got %b want %b", t, busy, eb);
            end
            total++;
            assert (done === ed) else begin
                bad++; $error("FAIL %s done: got %b want %b", t, done, ed);
            end
            total++;
            assert (so_l === eq[7]) else begin
                bad++; $error("FAIL %s so_l: got %b want %b", t, so_l, eq[7]);
            end
            total++;
            assert (so_r === eq[0]) else begin
                bad++; $error("FAIL %s so_r: got %b want %b", t, so_r, eq[0]);
            end
            total++;
            assert ((busy & done) === 1'b0) else begin
                bad++; $error("FAIL %s busy&done: got %b want 0", t, busy & done);
            end
        end
    endtask

    // Drive one cycle's inputs, queue the expected result, clock, compare.
    task automatic cyc(input logic rn, input logic e, input logic st,
                       input logic [2:0] m, input logic dl, input logic dr,
                       input logic [7:0] pd, input logic [3:0] cn,
                       input logic [7:0] eq, input logic eb, input logic ed,
                       input string t);
        reset_n = rn; en = e; start = st; mode = m;
        din_l = dl; din_r = dr; pdata = pd; count = cn;
        exp_q.push_back(eq); exp_b.push_back(eb);
        exp_d.push_back(ed); exp_t.push_back(t);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; start = 1'b0; mode = M_HOLD;
        din_l = 1'b0; din_r = 1'b0; pdata = 8'h00; count = 4'h0;

        //  rn  en  st  mode    dl dr pdata  cnt   q     b  d  tag
        cyc(0, 0, 0, M_HOLD, 0, 0, 8'h00, 4'h0, 8'h00, 0, 0, "rst0");
        cyc(1, 1, 0, M_LOAD, 0, 0, 8'hA5, 4'h0, 8'hA5, 0, 0, "ldA5");
        cyc(0, 1, 1, M_LOAD, 1, 1, 8'hFF, 4'hF, 8'h00, 0, 0, "rst1");

        cyc(1, 1, 0, M_LOAD, 0, 0, 8'h81, 4'h0, 8'h81, 0, 0, "ld81");
        cyc(1, 1, 0, M_SHL,  1, 0, 8'h00, 4'h0, 8'h03, 0, 0, "shl");
        cyc(1, 1, 0, M_SHR,  0, 0, 8'h00, 4'h0, 8'h01, 0, 0, "shr");
        cyc(1, 1, 0, M_ROR,  0, 0, 8'h00, 4'h0, 8'h80, 0, 0, "ror");
        cyc(1, 0, 0, M_SHL,  1, 1, 8'h00, 4'h0, 8'h80, 0, 0, "hold_en0");

        cyc(1, 1, 0, M_LOAD, 0, 0, 8'h96, 4'h0, 8'h96, 0, 0, "ld96");
        cyc(1, 1, 0, M_ASR,  0, 0, 8'h00, 4'h0, 8'hCB, 0, 0, "asr");
        cyc(1, 1, 0, M_ROL,  0, 0, 8'h00, 4'h0, 8'h97, 0, 0, "rol");
        cyc(1, 1, 0, M_CLR,  0, 0, 8'h00, 4'h0, 8'h00, 0, 0, "clr");
        cyc(1, 1, 0, M_SHR,  0, 1, 8'h00, 4'h0, 8'h80, 0, 0, "shr_din1");
        cyc(1, 1, 0, M_ASR,  0, 0, 8'h00, 4'h0, 8'hC0, 0, 0, "asr_neg");
        cyc(1, 1, 0, M_HOLD, 1, 1, 8'hFF, 4'h0, 8'hC0, 0, 0, "mode_hold");

        // start with non-burst modes is ignored
        cyc(1, 1, 1, M_LOAD, 0, 0, 8'h5A, 4'h3, 8'h5A, 0, 0, "st_load");
        cyc(1, 0, 1, M_CLR,  0, 0, 8'h00, 4'h3, 8'h5A, 0, 0, "st_clr_en0");

        // ROL burst count=3, no stall; block accepts a step in done cycle
        cyc(1, 1, 0, M_LOAD, 0, 0, 8'h01, 4'h0, 8'h01, 0, 0, "ld01a");
        cyc(1, 1, 1, M_ROL,  0, 0, 8'h00, 4'h3, 8'h01, 1, 0, "b3_acc");
        cyc(1, 1, 1, M_CLR,  1, 1, 8'hFF, 4'hF, 8'h02, 1, 0, "b3_s1");
        cyc(1, 1, 1, M_LOAD, 1, 1, 8'hFF, 4'hF, 8'h04, 1, 0, "b3_s2");
        cyc(1, 1, 0, M_SHL,  1, 1, 8'hFF, 4'hF, 8'h08, 1, 0, "b3_s3");
        cyc(1, 1, 0, M_CLR,  0, 0, 8'h00, 4'h0, 8'h08, 0, 1, "b3_done");
        cyc(1, 1, 0, M_SHL,  0, 0, 8'h00, 4'h0, 8'h10, 0, 0, "b3_after");

        // Same burst with a two-cycle stall after the first shift
        cyc(1, 1, 0, M_LOAD, 0, 0, 8'h01, 4'h0, 8'h01, 0, 0, "ld01b");
        cyc(1, 1, 1, M_ROL,  0, 0, 8'h00, 4'h3, 8'h01, 1, 0, "st_acc");
        cyc(1, 1, 0, M_HOLD, 0, 0, 8'h00, 4'h0, 8'h02, 1, 0, "st_s1");
        cyc(1, 0, 0, M_CLR,  0, 0, 8'h00, 4'h0, 8'h02, 1, 0, "stall1");
        cyc(1, 0, 1, M_LOAD, 0, 0, 8'hFF, 4'h0, 8'h02, 1, 0, "stall2");
        cyc(1, 1, 0, M_HOLD, 0, 0, 8'h00, 4'h0, 8'h04, 1, 0, "st_s2");
        cyc(1, 1, 0, M_HOLD, 0, 0, 8'h00, 4'h0, 8'h08, 1, 0, "st_s3");
        cyc(1, 1, 0, M_HOLD, 0, 0, 8'h00, 4'h0, 8'h08, 0, 1, "st_done");
        // new start in the done cycle, count=0
        cyc(1, 1, 1, M_ROR,  0, 0, 8'h00, 4'h0, 8'h08, 1, 0, "c0_acc");
        cyc(1, 1, 0, M_HOLD, 0, 0, 8'h00, 4'h0, 8'h08, 0, 1, "c0_done");
        cyc(1, 0, 0, M_HOLD, 0, 0, 8'h00, 4'h0, 8'h08, 0, 0, "c0_idle");

        // SHR burst uses live din_r, not the value at accept
        cyc(1, 1, 0, M_CLR,  0, 0, 8'h00, 4'h0, 8'h00, 0, 0, "clr2");
        cyc(1, 1, 1, M_SHR,  0, 0, 8'h00, 4'h2, 8'h00, 1, 0, "sr_acc");
        cyc(1, 1, 0, M_HOLD, 0, 1, 8'h00, 4'h0, 8'h80, 1, 0, "sr_s1");
        cyc(1, 1, 0, M_HOLD, 0, 0, 8'h00, 4'h0, 8'h40, 1, 0, "sr_s2");
        cyc(1, 1, 0, M_HOLD, 0, 0, 8'h00, 4'h0, 8'h40, 0, 1, "sr_done");

        // Reset mid-burst aborts with no done pulse
        cyc(1, 1, 0, M_LOAD, 0, 0, 8'h01, 4'h0, 8'h01, 0, 0, "ld01c");
        cyc(1, 1, 1, M_ROL,  0, 0, 8'h00, 4'h5, 8'h01, 1, 0, "ab_acc");
        cyc(1, 1, 0, M_HOLD, 0, 0, 8'h00, 4'h0, 8'h02, 1, 0, "ab_s1");
        cyc(1, 1, 0, M_HOLD, 0, 0, 8'h00, 4'h0, 8'h04, 1, 0, "ab_s2");
        cyc(0, 1, 1, M_ROL,  0, 0, 8'h00, 4'h5, 8'h00, 0, 0, "ab_rst");
        cyc(1, 1, 0, M_HOLD, 0, 0, 8'h00, 4'h0, 8'h00, 0, 0, "ab_nodone");
        cyc(1, 1, 0, M_SHL,  1, 0, 8'h00, 4'h0, 8'h01, 0, 0, "ab_shl");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
